// File: rtl/led_frame_sequencer_pkg.sv
// Shared timing constants, counter widths and FSM encoding for the LED frame sequencer.
// All counter compare values are pre-sized so that comparisons are width-exact.
package led_frame_sequencer_pkg;

  localparam int NBITS  = 120;
  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 63;
  localparam int TLATCH = 2500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BIT   = 2'd2,
    LATCH = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CYC_W  = $clog2(max_int(TBIT, TLATCH));
  localparam int BCNT_W = $clog2(NBITS);

  localparam logic [CYC_W-1:0]  CYC_BIT_LAST   = CYC_W'(TBIT - 1);
  localparam logic [CYC_W-1:0]  CYC_BIT_PRE    = CYC_W'(TBIT - 2);
  localparam logic [CYC_W-1:0]  CYC_LATCH_LAST = CYC_W'(TLATCH - 1);
  localparam logic [CYC_W-1:0]  CYC_LATCH_PRE  = CYC_W'(TLATCH - 2);
  localparam logic [CYC_W-1:0]  CYC_TOP        = CYC_W'(max_int(TBIT, TLATCH) - 1);
  localparam logic [CYC_W-1:0]  CYC_T0H        = CYC_W'(T0H);
  localparam logic [CYC_W-1:0]  CYC_T1H        = CYC_W'(T1H);
  localparam logic [BCNT_W-1:0] BIT_LAST_IDX   = BCNT_W'(NBITS - 1);

endpackage

// File: rtl/led_frame_sequencer_bit_timer.sv
// Cycle counter for bit and latch phases plus the high/low compare for the current bit.
// dout_hi looks one cycle ahead so the parent can register dout without adding latency.
module led_frame_sequencer_bit_timer
  import led_frame_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_val,
  output logic [CYC_W-1:0] cyc,
  output logic             dout_hi,
  output logic             bit_end,
  output logic             latch_end
);

  logic [CYC_W-1:0] cyc_nxt;
  logic [CYC_W-1:0] high_len;

  // start restarts the phase at 0 next cycle; otherwise count and saturate at the top
  always_comb begin
    cyc_nxt = cyc;
    if (start) begin
      cyc_nxt = '0;
    end else if (cyc != CYC_TOP) begin
      cyc_nxt = cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc <= '0;
    end else begin
      cyc <= cyc_nxt;
    end
  end

  assign high_len  = bit_val ? CYC_T1H : CYC_T0H;
  assign dout_hi   = (cyc_nxt < high_len);
  assign bit_end   = (cyc == CYC_BIT_LAST);
  assign latch_end = (cyc == CYC_LATCH_LAST);

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame FSM: load the frame register, send NBITS timed bits MSB first, then hold the latch gap.
// Start to LoadRegister is 1 cycle, first dout rise 2 cycles; all pulse outputs and dout are registered.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic auto_repeat,
  input  logic CurrentBit,
  output logic LoadRegister,
  output logic RotateRegisterLeft,
  output logic dout,
  output logic busy,
  output logic frame_done
);

  state_t            state;
  state_t            state_nxt;
  logic [BCNT_W-1:0] bitcnt;
  logic [BCNT_W-1:0] bitcnt_nxt;
  logic [CYC_W-1:0]  cyc;
  logic              timer_start;
  logic              dout_hi;
  logic              bit_end;
  logic              latch_end;
  logic              load_nxt;
  logic              rotate_nxt;
  logic              dout_nxt;
  logic              done_nxt;

  // Restart the cycle count on every phase entry; idle keeps it parked at 0
  assign timer_start = (state == IDLE) || (state == LOAD) ||
                       ((state == BIT) && bit_end) ||
                       ((state == LATCH) && latch_end);

  led_frame_sequencer_bit_timer u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (timer_start),
    .bit_val   (CurrentBit),
    .cyc       (cyc),
    .dout_hi   (dout_hi),
    .bit_end   (bit_end),
    .latch_end (latch_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt  = BIT;
        bitcnt_nxt = '0;
      end
      BIT: begin
        if (bit_end) begin
          if (bitcnt == BIT_LAST_IDX) begin
            state_nxt = LATCH;
          end else begin
            bitcnt_nxt = bitcnt + BCNT_W'(1);
          end
        end
      end
      LATCH: begin
        if (latch_end) begin
          state_nxt = auto_repeat ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Each output is decoded for the coming cycle so the registered copy lines up with the state.
  // The rotate pulse sits on the last cycle of a bit so the new MSB appears exactly at cyc 0.
  always_comb begin
    load_nxt   = (state_nxt == LOAD);
    rotate_nxt = (state == BIT) && (cyc == CYC_BIT_PRE) && (bitcnt != BIT_LAST_IDX);
    dout_nxt   = (state_nxt == BIT) && dout_hi;
    done_nxt   = (state == LATCH) && (cyc == CYC_LATCH_PRE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      LoadRegister       <= 1'b0;
      RotateRegisterLeft <= 1'b0;
      dout               <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      LoadRegister       <= load_nxt;
      RotateRegisterLeft <= rotate_nxt;
      dout               <= dout_nxt;
      frame_done         <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: per-cycle frame-position reference model plus frame-level vectors.
module tb_led_frame_sequencer;

  localparam int NB = 120;
  localparam int T0 = 20;
  localparam int T1 = 40;
  localparam int TB = 63;
  localparam int TL = 2500;
  // Position of frame_done counted from the LOAD cycle (t=0)
  localparam int FRAME_LAST = NB * TB + TL;

  typedef struct {
    logic [NB-1:0] sw;
    int            n_long;
    int            n_short;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic auto_repeat;
  logic CurrentBit;
  logic LoadRegister;
  logic RotateRegisterLeft;
  logic dout;
  logic busy;
  logic frame_done;
  logic [NB-1:0] sw;
  logic [NB-1:0] fr = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (LoadRegister) fr <= sw;
    else if (RotateRegisterLeft) fr <= {fr[NB-2:0], fr[NB-1]};
  end
  assign CurrentBit = fr[NB-1];

  led_frame_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .auto_repeat        (auto_repeat),
    .CurrentBit         (CurrentBit),
    .LoadRegister       (LoadRegister),
    .RotateRegisterLeft (RotateRegisterLeft),
    .dout               (dout),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit chk_en = 0;

  // Reference model: position t within the frame, bits latched at LOAD
  bit      m_act = 0;
  int      m_t   = 0;
  logic [NB-1:0] m_bits = '0;

  // Monitor counters (cumulative)
  int n_load = 0, n_rot = 0, n_done = 0, n_long = 0, n_short = 0;
  int n_badw = 0, n_badp = 0, n_busy_low = 0;
  int last_load = -1, last_done = -1, last_rise = 0, first_rise = -1, hi_w = 0;
  bit rise_vld = 0;
  logic dout_prev = 1'b0;
  logic [NB-1:0] dec = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] model_exp();
    logic ld, rot, dq, bz, dn;
    int b, c;
    ld = 0; rot = 0; dq = 0; bz = 0; dn = 0;
    if (m_act) begin
      bz = 1;
      ld = (m_t == 0);
      dn = (m_t == FRAME_LAST);
      if (m_t >= 1 && m_t <= NB * TB) begin
        b   = (m_t - 1) / TB;
        c   = (m_t - 1) % TB;
        dq  = (c < (m_bits[NB-1-b] ? T1 : T0));
        rot = (c == TB - 1) && (b < NB - 1);
      end
    end
    return {ld, rot, dq, bz, dn};
  endfunction

  function automatic logic [4:0] outs();
    return {LoadRegister, RotateRegisterLeft, dout, busy, frame_done};
  endfunction

  // Advance the model with the inputs the next posedge samples, then observe at the negedge
  task automatic tick();
    if (!reset) begin
      m_act = 0;
    end else if (!m_act) begin
      if (start) begin m_act = 1; m_t = 0; end
    end else if (m_t == FRAME_LAST) begin
      if (auto_repeat) m_t = 0;
      else m_act = 0;
    end else begin
      if (m_t == 0) m_bits = sw;
      m_t++;
    end
    @(negedge clk);
    cyc_n++;
    if (LoadRegister) begin n_load++; last_load = cyc_n; rise_vld = 0; end
    if (RotateRegisterLeft) n_rot++;
    if (frame_done) begin n_done++; last_done = cyc_n; end
    if (!busy) n_busy_low++;
    if (dout && !dout_prev) begin
      if (rise_vld && (cyc_n - last_rise) != TB) n_badp++;
      if (!rise_vld) first_rise = cyc_n;
      rise_vld = 1; last_rise = cyc_n; hi_w = 0;
    end
    if (dout) hi_w++;
    if (!dout && dout_prev) begin
      if (hi_w == T1) begin n_long++; dec = {dec[NB-2:0], 1'b1}; end
      else if (hi_w == T0) begin n_short++; dec = {dec[NB-2:0], 1'b0}; end
      else n_badw++;
    end
    dout_prev = dout;
    if (chk_en) chk($sformatf("outputs@%0d", cyc_n), int'(outs()), int'(model_exp()));
  endtask

  task automatic wait_done(output int dc);
    int n;
    dc = -1;
    n  = 0;
    while (dc < 0 && n < 12000) begin
      tick();
      n++;
      if (frame_done) dc = cyc_n;
    end
    if (dc < 0) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int k, d, l0, r0, dn0, lg0, sh0, bw0, bp0;
    l0 = n_load; r0 = n_rot; dn0 = n_done; lg0 = n_long; sh0 = n_short; bw0 = n_badw; bp0 = n_badp;
    sw = v.sw; auto_repeat = 0; start = 1; k = cyc_n;
    tick();
    start = 0;
    wait_done(d);
    chk($sformatf("v%0d_loads", idx), n_load - l0, 1);
    chk($sformatf("v%0d_rotates", idx), n_rot - r0, NB - 1);
    chk($sformatf("v%0d_long_pulses", idx), n_long - lg0, v.n_long);
    chk($sformatf("v%0d_short_pulses", idx), n_short - sh0, v.n_short);
    chk($sformatf("v%0d_bad_widths", idx), n_badw - bw0, 0);
    chk($sformatf("v%0d_bad_period", idx), n_badp - bp0, 0);
    chk_vec($sformatf("v%0d_decoded", idx), dec, v.sw);
    chk($sformatf("v%0d_load_cycle", idx), last_load, k + 1);
    chk($sformatf("v%0d_first_rise", idx), first_rise, k + 2);
    chk($sformatf("v%0d_done_cycle", idx), d, k + 2 + 10059);
    chk($sformatf("v%0d_done_count", idx), n_done - dn0, 1);
    tick();
    chk($sformatf("v%0d_busy_after", idx), busy, 0);
    repeat ($urandom_range(1, 8)) tick();
  endtask

  vec_t vecs[3];

  initial begin
    int d, d1, d2, l1, l2, l0, r0, bl0;
    reset = 0; start = 0; auto_repeat = 0; sw = '0;

    vecs[0].sw = {NB{1'b1}};  vecs[0].n_long = 120; vecs[0].n_short = 0;
    vecs[1].sw = {15{8'hAA}}; vecs[1].n_long = 60;  vecs[1].n_short = 60;
    vecs[2].sw = 120'hF;      vecs[2].n_long = 4;   vecs[2].n_short = 116;

    repeat (3) tick();
    chk("reset_outputs", int'(outs()), 0);
    chk_en = 1;
    reset  = 1;
    repeat (2) tick();

    for (int i = 0; i < 3; i++) run_frame(vecs[i], i);

    // start held high through a whole frame
    sw = NB'({$urandom(), $urandom(), $urandom(), $urandom()});
    start = 1; l0 = n_load;
    tick();
    wait_done(d);
    chk("cont_start_one_load", n_load - l0, 1);
    chk_vec("cont_start_decoded", dec, sw);
    tick();
    chk("cont_start_idle_gap", busy, 0);
    tick();
    chk("cont_start_reload", last_load, d + 2);
    start = 0;

    // reset in the middle of a bit of the second frame
    repeat ($urandom_range(50, 3000)) tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_mid_bit_%0d", i), int'(outs()), 0);
    end
    reset = 1;
    r0 = n_rot; l0 = n_load;
    repeat (300) tick();
    chk("no_rotate_after_reset", n_rot - r0, 0);
    chk("no_load_after_reset", n_load - l0, 0);
    chk("idle_after_reset", busy, 0);

    // two back-to-back frames via auto_repeat
    sw = NB'({$urandom(), $urandom(), $urandom(), $urandom()});
    auto_repeat = 1; start = 1; bl0 = n_busy_low;
    tick();
    start = 0;
    l1 = last_load;
    wait_done(d1);
    chk_vec("auto_decoded_1", dec, sw);
    tick();
    chk("auto_reload_next", last_load, d1 + 1);
    l2 = last_load;
    auto_repeat = 0;
    wait_done(d2);
    chk_vec("auto_decoded_2", dec, sw);
    chk("auto_frame_period", d2 - d1, 10061);
    chk("auto_load_period", l2 - l1, 10061);
    chk("auto_busy_never_low", n_busy_low - bl0, 0);
    tick();
    chk("auto_busy_after", busy, 0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
